// File: rtl/key_event.sv
// Per-key press / auto-repeat / release pulse generator for debounced, clock-synchronous keys.
// Each channel runs its own Idle -> Pressed -> Repeat machine and cycle counter.
module key_event #(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_held
);

  localparam int unsigned MaxCycles  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW       = $clog2(MaxCycles);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [1:0] {StIdle, StPressed, StRepeat} state_e;

  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CntW-1:0]   cnt_q   [N_KEYS];
  logic [CntW-1:0]   cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] press_d, repeat_d, release_d, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    repeat_d  = '0;
    release_d = '0;
    held_d    = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      unique case (state_q[i])
        StIdle: begin
          if (key_level[i]) begin
            press_d[i] = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = StPressed;
          end
        end
        StPressed: begin
          // Release is checked first so it wins over a repeat due on the same edge.
          if (!key_level[i]) begin
            release_d[i] = 1'b1;
            cnt_d[i]     = '0;
            state_d[i]   = StIdle;
          end else if (cnt_q[i] == HoldLast) begin
            repeat_d[i] = 1'b1;
            cnt_d[i]    = '0;
            state_d[i]  = StRepeat;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StRepeat: begin
          if (!key_level[i]) begin
            release_d[i] = 1'b1;
            cnt_d[i]     = '0;
            state_d[i]   = StIdle;
          end else if (cnt_q[i] == RepeatLast) begin
            repeat_d[i] = 1'b1;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = StIdle;
        end
      endcase
      held_d[i] = (state_d[i] == StRepeat);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      key_press   <= '0;
      key_repeat  <= '0;
      key_release <= '0;
      key_held    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_press   <= press_d;
      key_repeat  <= repeat_d;
      key_release <= release_d;
      key_held    <= held_d;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event (N_KEYS=4, HOLD_CYCLES=8, REPEAT_CYCLES=4).
// Expected output events are queued with the edge number at which they must appear.
module tb_key_event;

  localparam int unsigned NKeys = 4;
  localparam int unsigned Hold  = 8;
  localparam int unsigned Rep   = 4;

  logic             clk;
  logic             rst_n;
  logic [NKeys-1:0] key_level;
  logic [NKeys-1:0] key_press, key_repeat, key_release, key_held;

  key_event #(
    .N_KEYS       (NKeys),
    .HOLD_CYCLES  (Hold),
    .REPEAT_CYCLES(Rep)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_repeat (key_repeat),
    .key_release(key_release),
    .key_held   (key_held)
  );

  typedef struct {
    int unsigned      cyc;
    logic [NKeys-1:0] press;
    logic [NKeys-1:0] rep;
    logic [NKeys-1:0] rel;
    logic [NKeys-1:0] held;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_fail;
  logic [NKeys-1:0] held_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the number of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input int unsigned c, input logic [NKeys-1:0] p,
                           input logic [NKeys-1:0] r, input logic [NKeys-1:0] l,
                           input logic [NKeys-1:0] h);
    ev_t e;
    e.cyc = c; e.press = p; e.rep = r; e.rel = l; e.held = h;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any pulse or a change of key_held is an output event.
  initial held_prev = '0;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if ((key_press | key_repeat | key_release) != '0 || key_held != held_prev) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event at cycle %0d: press=%b repeat=%b release=%b held=%b",
                   cyc, key_press, key_repeat, key_release, key_held);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("key_press", 32'(key_press), 32'(e.press));
          chk("key_repeat", 32'(key_repeat), 32'(e.rep));
          chk("key_release", 32'(key_release), 32'(e.rel));
          chk("key_held", 32'(key_held), 32'(e.held));
        end
      end
      held_prev = key_held;
    end
  end

  initial begin
    int unsigned e0;
    rst_n     = 1'b0;
    key_level = 4'b1111;

    // Reset with all keys high, then fresh press on the first edge after reset.
    step(5);
    e0 = cyc + 1;
    expect_ev(e0,     4'b1111, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    rst_n = 1'b1;
    step(1);
    key_level = 4'b0000;
    step(3);

    // Short press on key0: three sampled-high edges.
    e0 = cyc + 1;
    expect_ev(e0,     4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 3, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    key_level = 4'b0001;
    step(3);
    key_level = 4'b0000;
    step(4);

    // Long hold on key1, released at E0+20 where a repeat would otherwise fire.
    e0 = cyc + 1;
    expect_ev(e0,      4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 8,  4'b0000, 4'b0010, 4'b0000, 4'b0010);
    expect_ev(e0 + 12, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    expect_ev(e0 + 16, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    expect_ev(e0 + 20, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    key_level = 4'b0010;
    step(20);
    key_level = 4'b0000;
    step(4);

    // key2 released exactly on the first-repeat edge.
    e0 = cyc + 1;
    expect_ev(e0,     4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 8, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    key_level = 4'b0100;
    step(8);
    key_level = 4'b0000;
    step(4);

    // key0 at E0, key3 at E0+3, both released at E0+17.
    e0 = cyc + 1;
    expect_ev(e0,      4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 3,  4'b1000, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 8,  4'b0000, 4'b0001, 4'b0000, 4'b0001);
    expect_ev(e0 + 11, 4'b0000, 4'b1000, 4'b0000, 4'b1001);
    expect_ev(e0 + 12, 4'b0000, 4'b0001, 4'b0000, 4'b1001);
    expect_ev(e0 + 15, 4'b0000, 4'b1000, 4'b0000, 4'b1001);
    expect_ev(e0 + 16, 4'b0000, 4'b0001, 4'b0000, 4'b1001);
    expect_ev(e0 + 17, 4'b0000, 4'b0000, 4'b1001, 4'b0000);
    key_level = 4'b0001;
    step(3);
    key_level = 4'b1001;
    step(14);
    key_level = 4'b0000;
    step(4);

    // Reset while key1 is in REPEAT: no release, held clears, then a fresh press.
    e0 = cyc + 1;
    expect_ev(e0,      4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 8,  4'b0000, 4'b0010, 4'b0000, 4'b0010);
    expect_ev(e0 + 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 11, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(e0 + 19, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    expect_ev(e0 + 21, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    key_level = 4'b0010;
    step(10);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(10);
    key_level = 4'b0000;
    step(6);

    chk("events_outstanding", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
